// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Latency and backpressure are defined by multdiv_seq; this file holds no logic.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } md_state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Loadable down-counter that tracks the remaining iterations, with a zero flag.
// Single-cycle load/decrement; load has priority and decrement saturates at zero.
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/multdiv_seq.sv
// Signed iterative multiply (shift-add) / divide (restoring) on one shared adder.
// Result pulse 34 cycles after start; starts are ignored while busy, never queued.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    md_state_t            state;
    logic                 op;
    logic                 sign_q;
    logic                 divz_q;
    logic                 exc_q;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 start_mult;
    logic                 start_div;
    logic                 iterating;
    logic                 last_iter;
    logic [MD_CNT_W-1:0]  cnt;
    logic                 cnt_zero;

    logic [WIDTH+1:0]     add_a;
    logic [WIDTH+1:0]     add_b;
    logic [WIDTH+1:0]     add_res;
    logic                 add_sub;
    logic [WIDTH:0]       mult_sum;

    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    // The ready-pulse cycle is excluded so a start can never overlap the completion.
    assign start_mult = (state == IDLE) && !data_resultRDY && ctrl_MULT;
    assign start_div  = (state == IDLE) && !data_resultRDY && !ctrl_MULT && ctrl_DIV;
    assign iterating  = (state == MULT) || (state == DIV);
    assign last_iter  = (cnt == MD_CNT_W'(1));

    multdiv_counter #(.CNT_W(MD_CNT_W)) u_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (start_mult || start_div),
        .load_val (MD_CNT_W'(WIDTH)),
        .dec      (iterating),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // One adder: accumulate in MULT, trial-subtract in DIV, negate (0 - x) in FIX.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            MULT: begin
                add_a = {2'b00, acc[2*WIDTH-1:WIDTH]};
                add_b = {2'b00, mag_a};
            end
            DIV: begin
                add_a   = {1'b0, acc[2*WIDTH-1:WIDTH-1]};
                add_b   = {2'b00, mag_b};
                add_sub = 1'b1;
            end
            FIX: begin
                add_b   = {2'b00, acc[WIDTH-1:0]};
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_res  = add_a + (add_sub ? ~add_b : add_b) + {{(WIDTH+1){1'b0}}, add_sub};
    assign mult_sum = mag_b[0] ? add_res[WIDTH:0] : {1'b0, acc[2*WIDTH-1:WIDTH]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op             <= MD_OP_MULT;
            sign_q         <= 1'b0;
            divz_q         <= 1'b0;
            exc_q          <= 1'b0;
            mag_a          <= '0;
            mag_b          <= '0;
            acc            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start_mult || start_div;
                    if (start_mult || start_div) begin
                        op     <= start_mult ? MD_OP_MULT : MD_OP_DIV;
                        sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        divz_q <= (data_operandB == '0);
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        acc    <= start_mult ? '0 : {{WIDTH{1'b0}}, abs_a};
                        state  <= start_mult ? MULT : DIV;
                    end
                end
                MULT: begin
                    acc   <= {mult_sum, acc[WIDTH-1:1]};
                    mag_b <= mag_b >> 1;
                    if (last_iter || cnt_zero) state <= FIX;
                end
                DIV: begin
                    if (!add_res[WIDTH+1]) begin
                        acc <= {add_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end
                    if (last_iter || cnt_zero) state <= FIX;
                end
                FIX: begin
                    if (op == MD_OP_MULT) begin
                        acc[WIDTH-1:0] <= sign_q ? add_res[WIDTH-1:0] : acc[WIDTH-1:0];
                        // A negative product may reach -2^(W-1); a positive one only 2^(W-1)-1.
                        exc_q <= sign_q ? ((|acc[2*WIDTH-1:WIDTH]) || (acc[WIDTH-1] && (|acc[WIDTH-2:0])))
                                        : (|acc[2*WIDTH-1:WIDTH-1]);
                    end else if (divz_q) begin
                        acc[WIDTH-1:0] <= '0;
                        exc_q          <= 1'b1;
                    end else begin
                        acc[WIDTH-1:0] <= sign_q ? add_res[WIDTH-1:0] : acc[WIDTH-1:0];
                        exc_q          <= !sign_q && acc[WIDTH-1];
                    end
                    state <= DONE;
                end
                DONE: begin
                    data_result    <= acc[WIDTH-1:0];
                    data_exception <= exc_q;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: hand-computed products/quotients, latency,
// busy window, ignored starts, mid-operation reset and back-to-back issue.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'h0;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues the start for the next rising edge (edge 0).
    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e,
                         input int pulse_cyc, input int ncyc);
        int first;
        int pulses;
        first  = 0;
        pulses = 0;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        for (int k = 1; k <= ncyc; k++) begin
            ctrl_DIV = (k == pulse_cyc);
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 33) check({tag, "_held"}, data_result, last_res);
            if (k == 34) begin
                check({tag, "_result"}, data_result, exp_r);
                check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exp_e});
                check({tag, "_busy34"}, {31'b0, busy}, 32'd1);
            end
            if (k == 35) check({tag, "_busy35"}, {31'b0, busy}, 32'd0);
        end
        ctrl_DIV = 1'b0;
        check({tag, "_latency"}, 32'(first), 32'd34);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        last_res = exp_r;
    endtask

    initial begin
        int pulses;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (2) @(negedge clock);
        check("rst_result", data_result, 32'h0);
        check("rst_exc", {31'b0, data_exception}, 32'd0);
        check("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_op("mul_7_m3",    1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, 40);
        do_op("mul_ovf",     1, 0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1, 0, 40);
        do_op("mul_min_1",   1, 0, 32'h80000000, 32'd1,        32'h80000000, 0, 0, 40);
        do_op("mul_min_m1",  1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 40);
        do_op("div_m7_2",    0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 40);
        do_op("div_100_7",   0, 1, 32'd100,      32'd7,        32'd14,       0, 0, 40);
        do_op("div_by0",     0, 1, 32'd5,        32'd0,        32'd0,        1, 0, 40);
        do_op("div_min_m1",  0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 40);
        do_op("both_start",  1, 1, 32'd6,        32'd3,        32'd18,       0, 10, 40);

        // Abort a multiply mid-flight with an asynchronous reset.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd11;
        data_operandB = 32'd13;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_result", data_result, 32'h0);
        check("abort_exc", {31'b0, data_exception}, 32'd0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        last_res = 32'h0;
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        check("abort_no_rdy", 32'(pulses), 32'd0);

        do_op("div_9_3", 0, 1, 32'd9, 32'd3, 32'd3, 0, 0, 34);
        @(negedge clock);
        do_op("b2b_mul", 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd20, 0, 0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
